// File: rtl/dom1_skinny_pkg.sv
// Shared types and constants for the masked Skinny round controller.
package dom1_skinny_pkg;

  localparam int unsigned NROUNDS_DEF = 40;
  localparam int unsigned DATA_W      = 128;
  localparam int unsigned RND_W       = 6;
  localparam int unsigned PH_W        = 3;
  localparam int unsigned EN_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [PH_W-1:0] PH_EN0 = PH_W'(0);
  localparam logic [PH_W-1:0] PH_EN1 = PH_W'(1);
  localparam logic [PH_W-1:0] PH_EN2 = PH_W'(2);
  localparam logic [PH_W-1:0] PH_EN3 = PH_W'(3);
  localparam logic [PH_W-1:0] PH_UPD = PH_W'(4);

  // Both shares travel together but are never combined.
  typedef struct packed {
    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s0;
  } shares_t;

  // One-hot sbox stage enable for a phase; zero in the update phase.
  function automatic logic [EN_W-1:0] phase_en(input logic [PH_W-1:0] ph);
    case (ph)
      PH_EN0:  return EN_W'(4'b0001);
      PH_EN1:  return EN_W'(4'b0010);
      PH_EN2:  return EN_W'(4'b0100);
      PH_EN3:  return EN_W'(4'b1000);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/dom1_skinny_phase_ctr.sv
// Mod-5 phase counter with round counter and last-round flag.
module dom1_skinny_phase_ctr
  import dom1_skinny_pkg::*;
#(
  parameter int unsigned NROUNDS = NROUNDS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  output logic [PH_W-1:0]  phase,
  output logic [RND_W-1:0] rnd,
  output logic [PH_W-1:0]  phase_nxt_c,
  output logic             last_c
);

  logic [RND_W-1:0] rnd_nxt_c;

  assign last_c = (rnd == RND_W'(NROUNDS - 1));

  // The round index only advances on a non-final update phase, so it never wraps.
  always_comb begin
    phase_nxt_c = phase;
    rnd_nxt_c   = rnd;
    if (clr) begin
      phase_nxt_c = PH_EN0;
      rnd_nxt_c   = '0;
    end else if (adv) begin
      if (phase == PH_UPD) begin
        phase_nxt_c = PH_EN0;
        if (!last_c) rnd_nxt_c = rnd + RND_W'(1);
      end else begin
        phase_nxt_c = phase + PH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= PH_EN0;
      rnd   <= '0;
    end else begin
      phase <= phase_nxt_c;
      rnd   <= rnd_nxt_c;
    end
  end

endmodule

// File: rtl/dom1_skinny_round_ctrl.sv
// Round sequencer for a first-order DOM Skinny core: owns the share registers and FSM.
module dom1_skinny_round_ctrl
  import dom1_skinny_pkg::*;
#(
  parameter int unsigned NROUNDS = NROUNDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] pt0,
  input  logic [DATA_W-1:0] pt1,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] ct0,
  output logic [DATA_W-1:0] ct1,
  output logic [DATA_W-1:0] sshi0,
  output logic [DATA_W-1:0] sshi1,
  input  logic [DATA_W-1:0] ssho0,
  input  logic [DATA_W-1:0] ssho1,
  output logic [EN_W-1:0]   en,
  output logic [RND_W-1:0]  rnd,
  output logic              tk_step
);

  state_e          state_q, state_d;
  shares_t         sh_q, sh_d;
  logic            clr_c, adv_c, upd_c, last_c;
  logic [PH_W-1:0] phase, phase_nxt_c;
  logic            ready_d, done_d, tk_step_d;
  logic [EN_W-1:0] en_d;

  dom1_skinny_phase_ctr #(.NROUNDS(NROUNDS)) u_phase_ctr (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr_c),
    .adv         (adv_c),
    .phase       (phase),
    .rnd         (rnd),
    .phase_nxt_c (phase_nxt_c),
    .last_c      (last_c)
  );

  assign upd_c = (phase == PH_UPD);
  assign ct0   = sh_q.s0;
  assign ct1   = sh_q.s1;
  assign sshi0 = sh_q.s0;
  assign sshi1 = sh_q.s1;

  // Next state and share capture.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    clr_c   = 1'b0;
    adv_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          clr_c   = 1'b1;
          sh_d    = '{s1: pt1, s0: pt0};
        end
      end
      ST_RUN: begin
        adv_c = 1'b1;
        if (upd_c) begin
          sh_d = '{s1: ssho1, s0: ssho0};
          if (last_c) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are precomputed from the next state so they leave the block registered.
  always_comb begin
    ready_d   = (state_d == ST_IDLE);
    done_d    = (state_d == ST_DONE);
    en_d      = '0;
    tk_step_d = 1'b0;
    if (state_d == ST_RUN) begin
      en_d      = phase_en(phase_nxt_c);
      tk_step_d = (phase_nxt_c == PH_UPD);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
      en      <= '0;
      tk_step <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      ready   <= ready_d;
      done    <= done_d;
      en      <= en_d;
      tk_step <= tk_step_d;
    end
  end

endmodule

// File: tb/tb_dom1_skinny_round_ctrl.sv
// Directed bench for dom1_skinny_round_ctrl with a stub round datapath and a result scoreboard.
module tb_dom1_skinny_round_ctrl;

  typedef struct packed {
    logic [127:0] c0;
    logic [127:0] c1;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  // NROUNDS=40 instance
  logic         d_start, d_ready, d_done, d_tk;
  logic [127:0] d_pt0, d_pt1, d_ct0, d_ct1, d_sshi0, d_sshi1, d_ssho0, d_ssho1;
  logic [3:0]   d_en;
  logic [5:0]   d_rnd;
  // NROUNDS=1 instance
  logic         e_start, e_ready, e_done, e_tk;
  logic [127:0] e_pt0, e_pt1, e_ct0, e_ct1, e_sshi0, e_sshi1, e_ssho0, e_ssho1;
  logic [3:0]   e_en;
  logic [5:0]   e_rnd;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  // Stand-in round function: distinct per share and per round index.
  function automatic logic [127:0] f0(input logic [127:0] s, input logic [5:0] r);
    return {s[126:0], s[127]} ^ {122'h0, r};
  endfunction
  function automatic logic [127:0] f1(input logic [127:0] s, input logic [5:0] r);
    return s ^ {58'h0, r, 64'hC3A5_5A3C_0F1E_2D4B};
  endfunction

  function automatic exp_t model(input logic [127:0] p0, input logic [127:0] p1, input int n);
    exp_t e;
    e.c0 = p0;
    e.c1 = p1;
    for (int r = 0; r < n; r++) begin
      e.c0 = f0(e.c0, 6'(r));
      e.c1 = f1(e.c1, 6'(r));
    end
    return e;
  endfunction

  function automatic logic [3:0] en_exp(input int ph);
    logic [3:0] one;
    one = 4'b0001;
    return (ph < 4) ? 4'(one << ph) : 4'b0000;
  endfunction

  assign d_ssho0 = f0(d_sshi0, d_rnd);
  assign d_ssho1 = f1(d_sshi1, d_rnd);
  assign e_ssho0 = f0(e_sshi0, e_rnd);
  assign e_ssho1 = f1(e_sshi1, e_rnd);

  dom1_skinny_round_ctrl #(.NROUNDS(40)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(d_start), .pt0(d_pt0), .pt1(d_pt1),
    .ready(d_ready), .done(d_done), .ct0(d_ct0), .ct1(d_ct1),
    .sshi0(d_sshi0), .sshi1(d_sshi1), .ssho0(d_ssho0), .ssho1(d_ssho1),
    .en(d_en), .rnd(d_rnd), .tk_step(d_tk)
  );

  dom1_skinny_round_ctrl #(.NROUNDS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(e_start), .pt0(e_pt0), .pt1(e_pt1),
    .ready(e_ready), .done(e_done), .ct0(e_ct0), .ct1(e_ct1),
    .sshi0(e_sshi0), .sshi1(e_sshi1), .ssho0(e_ssho0), .ssho1(e_ssho1),
    .en(e_en), .rnd(e_rnd), .tk_step(e_tk)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_d(input string tag);
    chk({tag, " ready"}, 128'(d_ready), 128'(1));
    chk({tag, " en"},    128'(d_en),    128'(0));
    chk({tag, " done"},  128'(d_done),  128'(0));
    chk({tag, " tk"},    128'(d_tk),    128'(0));
    chk({tag, " rnd"},   128'(d_rnd),   128'(0));
    chk({tag, " ct0"},   d_ct0,         128'(0));
    chk({tag, " ct1"},   d_ct1,         128'(0));
  endtask

  // Called at a negedge in IDLE; start is sampled at the next edge (edge 0).
  task automatic run40(input logic [127:0] p0, input logic [127:0] p1,
                       input int busy_a, input int busy_b, input bit busy_done,
                       input int abort_at);
    exp_t e;
    int   tk_cnt;
    tk_cnt = 0;
    sb.push_back(model(p0, p1, 40));
    chk("idle ready", 128'(d_ready), 128'(1));
    d_pt0 = p0; d_pt1 = p1; d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    chk("load sshi0", d_sshi0, p0);
    chk("load sshi1", d_sshi1, p1);
    for (int c = 1; c <= 200; c++) begin
      chk("run en",    128'(d_en),    128'(en_exp((c - 1) % 5)));
      chk("run tk",    128'(d_tk),    128'(((c - 1) % 5) == 4));
      chk("run rnd",   128'(d_rnd),   128'((c - 1) / 5));
      chk("run done",  128'(d_done),  128'(0));
      chk("run ready", 128'(d_ready), 128'(0));
      if (d_tk) tk_cnt++;
      if (c == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_d("abort");
        rst_n = 1'b1;
        void'(sb.pop_back());
        return;
      end
      if (c == busy_a || c == busy_b) begin
        d_start = 1'b1;
        d_pt0 = ~p0; d_pt1 = ~p1;
      end else begin
        d_start = 1'b0;
      end
      @(negedge clk);
    end
    d_start = 1'b0;
    chk("tk count",   128'(tk_cnt),  128'(40));
    chk("done pulse", 128'(d_done),  128'(1));
    chk("done en",    128'(d_en),    128'(0));
    chk("done ready", 128'(d_ready), 128'(0));
    e = sb.pop_front();
    chk("ct0", d_ct0, e.c0);
    chk("ct1", d_ct1, e.c1);
    chk("ct unmasked", d_ct0 ^ d_ct1, e.c0 ^ e.c1);
    if (busy_done) begin
      d_start = 1'b1;
      d_pt0 = ~p0; d_pt1 = ~p1;
    end
    @(negedge clk);
    d_start = 1'b0;
    chk("post done", 128'(d_done),  128'(0));
    chk("post ready", 128'(d_ready), 128'(1));
    chk("hold ct0", d_ct0, e.c0);
    chk("hold ct1", d_ct1, e.c1);
  endtask

  task automatic run1(input logic [127:0] p0, input logic [127:0] p1);
    exp_t         e;
    logic [127:0] cap0, cap1;
    cap0 = '0; cap1 = '0;
    sb.push_back(model(p0, p1, 1));
    e_pt0 = p0; e_pt1 = p1; e_start = 1'b1;
    @(negedge clk);
    e_start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      chk("n1 en",   128'(e_en),   128'(en_exp(c - 1)));
      chk("n1 tk",   128'(e_tk),   128'(c == 5));
      chk("n1 done", 128'(e_done), 128'(0));
      if (c == 5) begin cap0 = e_ssho0; cap1 = e_ssho1; end
      @(negedge clk);
    end
    e = sb.pop_front();
    chk("n1 done pulse", 128'(e_done), 128'(1));
    chk("n1 ct0", e_ct0, e.c0);
    chk("n1 ct1", e_ct1, e.c1);
    chk("n1 ct0 cap", e_ct0, cap0);
    chk("n1 ct1 cap", e_ct1, cap1);
    @(negedge clk);
    chk("n1 ready", 128'(e_ready), 128'(1));
    chk("n1 done low", 128'(e_done), 128'(0));
  endtask

  initial begin
    logic [127:0] pa, pb, pc, pd;
    logic [127:0] pconst;
    pconst = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    pa = {$urandom, $urandom, $urandom, $urandom};
    pb = {$urandom, $urandom, $urandom, $urandom};
    pc = {$urandom, $urandom, $urandom, $urandom};
    pd = {$urandom, $urandom, $urandom, $urandom};
    rst_n = 1'b0;
    d_start = 1'b0; d_pt0 = '0; d_pt1 = '0;
    e_start = 1'b0; e_pt0 = '0; e_pt1 = '0;
    repeat (2) @(negedge clk);
    chk_reset_d("reset");
    chk("reset n1 ready", 128'(e_ready), 128'(1));
    chk("reset n1 en",    128'(e_en),    128'(0));
    // Reset must win over a simultaneous start.
    d_start = 1'b1; d_pt0 = pa; d_pt1 = pb;
    @(negedge clk);
    d_start = 1'b0;
    chk_reset_d("rst prio");
    rst_n = 1'b1;
    @(negedge clk);

    run40(pa, pa ^ pconst, 3, 100, 1'b1, 0);
    run40(pb, pb ^ ~pconst, 0, 0, 1'b0, 0);
    run40(pc, pc ^ pconst, 0, 0, 1'b0, 73);
    for (int i = 0; i < 3; i++) begin
      chk("abort no done", 128'(d_done),  128'(0));
      chk("abort ready",   128'(d_ready), 128'(1));
      @(negedge clk);
    end
    run40(pd, pd ^ pconst, 0, 0, 1'b0, 0);

    run1(pa, pa ^ pconst);
    run1(pc, ~pc);

    chk("scoreboard empty", 128'(sb.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dom1_skinny_round_ctrl.md
DOM1_SKINNY_ROUND_CTRL -- requirements
Module: dom1_skinny_round_ctrl

Interface
REQ-001 SHALL have parameter NROUNDS, default 40, number of Skinny rounds per block (legal 1..63).
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request to encipher pt shares
- pt0, pt1  in  128  plaintext shares
- ready  out  1  high in IDLE only
- done  out  1  one-cycle completion pulse
- ct0, ct1  out  128  state register shares
- sshi0, sshi1  out  128  state shares to round datapath
- ssho0, ssho1  in  128  round datapath output shares
- en  out  4  sbox stage enables to round datapath
- rnd  out  6  current round index
- tk_step  out  1  advance tweakey schedule (ksh shares)

Function
REQ-003 SHALL hold two 128-bit share registers, state0 and state1, driving sshi0/ct0 and sshi1/ct1 respectively; shares are never combined.
REQ-004 SHALL implement FSM states IDLE, RUN and DONE, plus a phase counter 0..4 and a round counter 0..NROUNDS-1.
REQ-005 IDLE: ready=1; start=1 SHALL load state0<=pt0 and state1<=pt1, clear phase and rnd, and go to RUN at the same edge.
REQ-006 RUN, phases 0..3: en SHALL be one-hot 1<<phase (0001, 0010, 0100, 1000), phase increments.
REQ-007 RUN, phase 4: en=0000, tk_step=1, state0<=ssho0, state1<=ssho1, and phase<=0.
REQ-008 RUN, phase 4: if rnd==NROUNDS-1, go to DONE; else rnd<=rnd+1 and stay in RUN.
REQ-009 DONE: done=1 for exactly one cycle, then IDLE. ct0/ct1 SHALL hold the result until the next accepted start.
REQ-010 en SHALL be 0000 in IDLE, DONE and phase 4, so sbox registers hold.
REQ-011 tk_step SHALL be 0 outside RUN phase 4.
REQ-012 start SHALL be ignored in RUN and DONE; no queuing.
REQ-013 Latency: with start accepted at edge 0, done SHALL be high in cycle 5*NROUNDS+1 (201 for NROUNDS=40).
REQ-014 rnd SHALL wrap only via a new start, never by overflow; no arithmetic beyond 6 bits.

Reset
REQ-015 rst_n=0 at a clock edge SHALL force IDLE, phase=0, rnd=0, state0=state1=0, en=0000, done=0, tk_step=0, ready=1 after that edge.
REQ-016 Reset mid-RUN SHALL abort without asserting done; the next start SHALL behave as from power-up.
REQ-017 Reset SHALL take priority over start in the same cycle.

Structure
REQ-018 Shared package dom1_skinny_pkg SHALL hold: NROUNDS default, FSM state encoding, phase constants (PH_EN0..PH_EN3, PH_UPD=4).
REQ-019 SHALL contain one sub-module, dom1_skinny_phase_ctr (mod-5 phase counter with round counter and last-round flag); FSM and share registers stay in the top.

Verification
REQ-020 Reset: hold rst_n=0 for 2 cycles -> ready=1, en=0000, done=0, tk_step=0, ct0=ct1=0.
REQ-021 Known answer: top with dom1_skinny_rnd and a bench tweakey model, pt0 random, pt1=pt0^P, fresh random r each cycle, NROUNDS=40 -> done in cycle 201 and ct0^ct1 equals the unmasked Skinny-128-384 golden output for P.
REQ-022 Sequencing: during RUN, en cycles 0001, 0010, 0100, 1000, 0000; tk_step high every 5th cycle; rnd steps 0..39; exactly 40 tk_step pulses.
REQ-023 Busy start: pulse start at cycles 3, 100 and 201 (done cycle) -> no reload, state unaffected, single done; start at cycle 202 is accepted.
REQ-024 Mid-run reset: rst_n=0 at cycle 73 -> all outputs at reset values next cycle, no done pulse; a new start then completes in 201 cycles with the correct result.
REQ-025 NROUNDS=1: start -> en 0001..1000, one tk_step, done in cycle 6, ct shares equal ssho shares captured at phase 4.
